psdifir_mc_core: RTL

PSDIFIR_MC_CORE -- requirements
Module: psdifir_mc_core

---
 rtl/psdifir_mc_core.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/psdifir_mc_core.sv
// ============================================================================
// psdifir_mc_core : multichannel FIR filter, one shared MAC, circular buffers
// Revision 1.0
// ============================================================================
`default_nettype none

module psdifir_mc_core #(
   parameter int DATA_W    = 18,
   parameter int COEF_W    = 18,
   parameter int COEF_FRAC = 17,
   parameter int NTAPS     = 64,
   parameter int NCH       = 2
) (
   input  logic                       clockext100MHz,
   input  logic                       reset,
   input  logic                       datain_ready,
   input  logic [NCH*DATA_W-1:0]      data_in,
   input  logic                       bypass,
   input  logic                       coef_we,
   input  logic [$clog2(NTAPS)-1:0]   coef_addr,
   input  logic [COEF_W-1:0]          coef_data,
   output logic [NCH*DATA_W-1:0]      data_out,
   output logic                       dataout_ready,
   output logic                       busy,
   output logic                       overrun
);

   localparam int TAP_W  = $clog2(NTAPS);
   localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + TAP_W;
   localparam int RND_W  = ACC_W + 1;

   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAPS - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);

   localparam logic signed [RND_W-1:0] HALF =
      {{(RND_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
   localparam logic signed [RND_W-1:0] SAT_MAX =
      {{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [RND_W-1:0] SAT_MIN =
      {{(RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_WRITE = 3'd2,
      S_MAC   = 3'd3,
      S_ROUND = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                     state_q, state_d;
   logic [TAP_W-1:0]           wp_q, wp_d;
   logic [TAP_W-1:0]           k_q, k_d;
   logic [CH_W-1:0]            ch_q, ch_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic [NCH*DATA_W-1:0]      din_q, din_d;
   logic [NCH*DATA_W-1:0]      res_q, res_d;
   logic [NCH*DATA_W-1:0]      dout_q, dout_d;
   logic                       byp_q, byp_d;
   logic                       rdy_q, rdy_d;
   logic                       ovr_q, ovr_d;

   logic                       clr_we;
   logic                       wr_we;
   logic                       coef_wr;
   logic [TAP_W-1:0]           rd_idx;
   logic [DATA_W-1:0]          rd_smp [NCH];
   logic [COEF_W-1:0]          coef_mem [NTAPS];
   logic signed [DATA_W-1:0]   x_s;
   logic signed [COEF_W-1:0]   h_s;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [RND_W-1:0]    rnd;
   logic signed [RND_W-1:0]    shr;
   logic [DATA_W-1:0]          sat;

   // Coefficients survive reset; they change only while the core is idle.
   assign coef_wr = coef_we && (state_q == S_IDLE);

   always_ff @(posedge clockext100MHz) begin
      if (coef_wr) begin
         coef_mem[coef_addr] <= coef_data;
      end
   end

   // Tap k reads the sample written k frames ago.
   assign rd_idx = wp_q - k_q;

   for (genvar c = 0; c < NCH; c++) begin : g_chbuf
      logic [DATA_W-1:0] mem [NTAPS];
      logic              we;
      logic [TAP_W-1:0]  wa;
      logic [DATA_W-1:0] wd;

      always_comb begin
         we = wr_we;
         wa = wp_q;
         wd = din_q[c*DATA_W +: DATA_W];
         if (clr_we) begin
            we = (ch_q == CH_W'(c));
            wa = k_q;
            wd = '0;
         end
      end

      always_ff @(posedge clockext100MHz) begin
         if (we) begin
            mem[wa] <= wd;
         end
      end

      assign rd_smp[c] = mem[rd_idx];
   end

   assign x_s      = $signed(rd_smp[ch_q]);
   assign h_s      = $signed(coef_mem[k_q]);
   assign prod     = x_s * h_s;
   assign prod_ext = {{TAP_W{prod[PROD_W-1]}}, prod};

   // Round half up, then clamp into the sample range.
   always_comb begin
      rnd = $signed({acc_q[ACC_W-1], acc_q}) + HALF;
      shr = rnd >>> COEF_FRAC;
      if (shr > SAT_MAX) begin
         sat = SAT_MAX[DATA_W-1:0];
      end else if (shr < SAT_MIN) begin
         sat = SAT_MIN[DATA_W-1:0];
      end else begin
         sat = shr[DATA_W-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      k_d     = k_q;
      ch_d    = ch_q;
      acc_d   = acc_q;
      din_d   = din_q;
      res_d   = res_q;
      dout_d  = dout_q;
      byp_d   = byp_q;
      rdy_d   = 1'b0;
      ovr_d   = ovr_q;
      clr_we  = 1'b0;
      wr_we   = 1'b0;

      if (datain_ready && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         S_CLEAR: begin
            clr_we = 1'b1;
            k_d    = k_q + 1'b1;
            if (k_q == TAP_LAST) begin
               if (ch_q == CH_LAST) begin
                  ch_d    = '0;
                  state_d = S_IDLE;
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end
         end
         S_IDLE: begin
            if (datain_ready) begin
               din_d   = data_in;
               byp_d   = bypass;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            wr_we   = 1'b1;
            k_d     = '0;
            ch_d    = '0;
            acc_d   = '0;
            state_d = byp_q ? S_DONE : S_MAC;
         end
         S_MAC: begin
            acc_d = acc_q + prod_ext;
            k_d   = k_q + 1'b1;
            if (k_q == TAP_LAST) begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            for (int c = 0; c < NCH; c++) begin
               if (ch_q == CH_W'(c)) begin
                  res_d[c*DATA_W +: DATA_W] = sat;
               end
            end
            acc_d = '0;
            k_d   = '0;
            if (ch_q == CH_LAST) begin
               ch_d    = '0;
               state_d = S_DONE;
            end else begin
               ch_d    = ch_q + 1'b1;
               state_d = S_MAC;
            end
         end
         S_DONE: begin
            dout_d  = byp_q ? din_q : res_q;
            rdy_d   = 1'b1;
            wp_d    = wp_q + 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clockext100MHz or posedge reset) begin
      if (reset) begin
         state_q <= S_CLEAR;
         wp_q    <= '0;
         k_q     <= '0;
         ch_q    <= '0;
         acc_q   <= '0;
         din_q   <= '0;
         res_q   <= '0;
         dout_q  <= '0;
         byp_q   <= 1'b0;
         rdy_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         k_q     <= k_d;
         ch_q    <= ch_d;
         acc_q   <= acc_d;
         din_q   <= din_d;
         res_q   <= res_d;
         dout_q  <= dout_d;
         byp_q   <= byp_d;
         rdy_q   <= rdy_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_out      = dout_q;
   assign dataout_ready = rdy_q;
   assign overrun       = ovr_q;
   assign busy          = (state_q != S_IDLE);

endmodule

`default_nettype wire
